// File: rtl/perfmon_pkg.sv
// Shared definitions for the multi-channel performance monitor: FSM encodings,
// read-select codes and the saturating increment used by every counter.
package perfmon_pkg;

  typedef logic [1:0] perfmon_state_t;

  localparam perfmon_state_t ST_IDLE      = 2'd0;
  localparam perfmon_state_t ST_RUN       = 2'd1;
  localparam perfmon_state_t ST_DONE_WAIT = 2'd2;

  localparam logic [2:0] SEL_TXN      = 3'd0;
  localparam logic [2:0] SEL_BUSY     = 3'd1;
  localparam logic [2:0] SEL_ITER     = 3'd2;
  localparam logic [2:0] SEL_STALL    = 3'd3;
  localparam logic [2:0] SEL_LAST_LAT = 3'd4;
  localparam logic [2:0] SEL_MIN_LAT  = 3'd5;
  localparam logic [2:0] SEL_MAX_LAT  = 3'd6;
  localparam logic [2:0] SEL_STATUS   = 3'd7;

  // Increment that sticks at 2**width-1 instead of wrapping (width <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_v) ? max_v : value + 64'd1;
  endfunction

endpackage

// File: rtl/perfmon_channel.sv
// One monitored channel: ap_ctrl_hs FSM, latency counter and statistics.
// Min/max latency registers exist only when PERFMON_MINMAX_EN is defined.
module perfmon_channel
  import perfmon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mon_en,
  input  logic               mon_clr,
  input  logic               start,
  input  logic               done,
  input  logic               cont,
  input  logic               iter_end,
  input  logic               stall,
  output logic [8*CNT_W-1:0] stats,
  output perfmon_state_t     state,
  output logic               ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  perfmon_state_t   state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d, txn_q, txn_d, busy_q, busy_d;
  logic [CNT_W-1:0] iter_q, iter_d, stall_q, stall_d, last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             active, sat_hit;
  logic [CNT_W-1:0] lat_now, min_w, max_w;
  logic [CNT_W-1:0] word [8];

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), CNT_W));
  endfunction

`ifdef PERFMON_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
  assign min_w = min_q;
  assign max_w = max_q;
`else
  assign min_w = '0;
  assign max_w = '0;
`endif

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    txn_d   = txn_q;
    busy_d  = busy_q;
    iter_d  = iter_q;
    stall_d = stall_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
`ifdef PERFMON_MINMAX_EN
    min_d   = min_q;
    max_d   = max_q;
`endif
    sat_hit = 1'b0;
    // The start-accept cycle already belongs to the transaction, so it is
    // counted as busy and gives latency 1 for a same-cycle done.
    active  = (state_q == ST_RUN) || ((state_q == ST_IDLE) && start);
    lat_now = (state_q == ST_RUN) ? inc(lat_q) : CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lat_d = CNT_ONE;
          if (done) state_d = cont ? ST_IDLE : ST_DONE_WAIT;
          else      state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        lat_d   = lat_now;
        sat_hit = (lat_q == CNT_MAX);
        if (done) begin
          if (start) lat_d = CNT_ONE;
          else       state_d = cont ? ST_IDLE : ST_DONE_WAIT;
        end
      end
      ST_DONE_WAIT: begin
        if (cont) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (mon_en) begin
      if (active) begin
        busy_d  = inc(busy_q);
        sat_hit = sat_hit | (busy_q == CNT_MAX);
        if (stall) begin
          stall_d = inc(stall_q);
          sat_hit = sat_hit | (stall_q == CNT_MAX);
        end
        if (done) begin
          txn_d   = inc(txn_q);
          sat_hit = sat_hit | (txn_q == CNT_MAX);
          last_d  = lat_now;
`ifdef PERFMON_MINMAX_EN
          min_d   = (lat_now < min_q) ? lat_now : min_q;
          max_d   = (lat_now > max_q) ? lat_now : max_q;
`endif
        end
      end
      if (iter_end) begin
        iter_d  = inc(iter_q);
        sat_hit = sat_hit | (iter_q == CNT_MAX);
      end
    end

    if (sat_hit) ovf_d = 1'b1;

    if (mon_clr) begin
      state_d = ST_IDLE;
      lat_d   = '0;
      txn_d   = '0;
      busy_d  = '0;
      iter_d  = '0;
      stall_d = '0;
      last_d  = '0;
      ovf_d   = 1'b0;
`ifdef PERFMON_MINMAX_EN
      min_d   = '1;
      max_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      txn_q   <= '0;
      busy_q  <= '0;
      iter_q  <= '0;
      stall_q <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef PERFMON_MINMAX_EN
      min_q   <= '1;
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      txn_q   <= txn_d;
      busy_q  <= busy_d;
      iter_q  <= iter_d;
      stall_q <= stall_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
`ifdef PERFMON_MINMAX_EN
      min_q   <= min_d;
      max_q   <= max_d;
`endif
    end
  end

  assign word[SEL_TXN]      = txn_q;
  assign word[SEL_BUSY]     = busy_q;
  assign word[SEL_ITER]     = iter_q;
  assign word[SEL_STALL]    = stall_q;
  assign word[SEL_LAST_LAT] = last_q;
  assign word[SEL_MIN_LAT]  = min_w;
  assign word[SEL_MAX_LAT]  = max_w;
  assign word[SEL_STATUS]   = CNT_W'({ovf_q, state_q});

  for (genvar w = 0; w < 8; w++) begin : g_stats
    assign stats[w*CNT_W +: CNT_W] = word[w];
  end

  assign state = state_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/perfmon_multi_channel.sv
// Multi-channel performance monitor top: per-channel statistics plus a
// registered read port. Define PERFMON_MINMAX_EN to build min/max latency.
module perfmon_multi_channel
  import perfmon_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int CH_AW  = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              mon_en,
  input  logic              mon_clr,
  input  logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_continue,
  input  logic [NUM_CH-1:0] ch_iter_end,
  input  logic [NUM_CH-1:0] ch_stall,
  input  logic              rd_req,
  input  logic [CH_AW-1:0]  rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] overflow,
  output logic              any_busy
);

  logic [8*CNT_W-1:0] ch_stats [NUM_CH];
  perfmon_state_t     ch_state [NUM_CH];
  logic               rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perfmon_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (ap_clk),
      .rst_n    (ap_rst_n),
      .mon_en   (mon_en),
      .mon_clr  (mon_clr),
      .start    (ch_start[g]),
      .done     (ch_done[g]),
      .cont     (ch_continue[g]),
      .iter_end (ch_iter_end[g]),
      .stall    (ch_stall[g]),
      .stats    (ch_stats[g]),
      .state    (ch_state[g]),
      .ovf      (overflow[g])
    );
  end

  // Read mux sees the registered stats, so a read returns pre-update values;
  // out-of-range channels match no index and fall through to zero.
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = rd_req;
    any_busy   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_state[i] != ST_IDLE) any_busy = 1'b1;
      if (rd_req && (int'(rd_ch) == i)) rd_data_d = ch_stats[i][int'(rd_sel)*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_perfmon_multi_channel.sv
// Directed bench for perfmon_multi_channel with a 4-bit counter build so
// saturation is reachable; min/max expectations follow PERFMON_MINMAX_EN.
module tb_perfmon_multi_channel;
  import perfmon_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int CH_AW  = 4;

`ifdef PERFMON_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic              mon_en = 1'b0;
  logic              mon_clr = 1'b0;
  logic [NUM_CH-1:0] ch_start = '0;
  logic [NUM_CH-1:0] ch_done = '0;
  logic [NUM_CH-1:0] ch_continue = '1;
  logic [NUM_CH-1:0] ch_iter_end = '0;
  logic [NUM_CH-1:0] ch_stall = '0;
  logic              rd_req = 1'b0;
  logic [CH_AW-1:0]  rd_ch = '0;
  logic [2:0]        rd_sel = '0;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] overflow;
  logic              any_busy;

  int checks = 0;
  int errors = 0;

  perfmon_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_AW(CH_AW)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .mon_en      (mon_en),
    .mon_clr     (mon_clr),
    .ch_start    (ch_start),
    .ch_done     (ch_done),
    .ch_continue (ch_continue),
    .ch_iter_end (ch_iter_end),
    .ch_stall    (ch_stall),
    .rd_req      (rd_req),
    .rd_ch       (rd_ch),
    .rd_sel      (rd_sel),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .overflow    (overflow),
    .any_busy    (any_busy)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [CNT_W-1:0] mm(input logic [CNT_W-1:0] v);
    return MM ? v : '0;
  endfunction

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input int ch, input logic [2:0] sel, input string tag,
                        input logic [CNT_W-1:0] exp);
    rd_req = 1'b1;
    rd_ch  = CH_AW'(ch);
    rd_sel = sel;
    step();
    rd_req = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    // Power-on reset
    step();
    step();
    ap_rst_n = 1'b1;
    check("por_any_busy", 32'(any_busy), 32'd0);
    check("por_rd_valid", 32'(rd_valid), 32'd0);
    check("por_rd_data", 32'(rd_data), 32'd0);
    check("por_overflow", 32'(overflow), 32'd0);

    // Reset in the middle of a transaction
    mon_en = 1'b1;
    ch_start[0] = 1'b1;
    step();
    ch_start[0] = 1'b0;
    repeat (3) step();
    check("midrun_busy_flag", 32'(any_busy), 32'd1);
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
    check("rst_any_busy", 32'(any_busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rd_chk(0, SEL_BUSY, "rst_busy", 4'd0);
    rd_chk(0, SEL_TXN, "rst_txn", 4'd0);
    rd_chk(0, SEL_MIN_LAT, "rst_min", mm(4'hF));
    rd_chk(0, SEL_STATUS, "rst_status", 4'd0);

    // Single transaction: start cycle 0, done cycle 4
    ch_start[0] = 1'b1;
    step();
    ch_start[0] = 1'b0;
    repeat (3) step();
    ch_done[0] = 1'b1;
    step();
    ch_done[0] = 1'b0;
    rd_chk(0, SEL_TXN, "one_txn", 4'd1);
    rd_chk(0, SEL_BUSY, "one_busy", 4'd5);
    rd_chk(0, SEL_LAST_LAT, "one_last", 4'd5);
    rd_chk(0, SEL_MIN_LAT, "one_min", mm(4'd5));
    rd_chk(0, SEL_MAX_LAT, "one_max", mm(4'd5));
    rd_chk(0, SEL_STATUS, "one_status", 4'd0);

    // Latency 3 ending with continue low; start held in DONE_WAIT is ignored
    ch_start[1] = 1'b1;
    step();
    ch_start[1] = 1'b0;
    step();
    ch_done[1] = 1'b1;
    ch_continue[1] = 1'b0;
    step();
    ch_done[1] = 1'b0;
    ch_start[1] = 1'b1;
    step();
    step();
    ch_start[1] = 1'b0;
    rd_chk(1, SEL_STATUS, "dw_status", 4'd2);
    rd_chk(1, SEL_TXN, "dw_txn", 4'd1);
    ch_continue[1] = 1'b1;
    step();
    ch_start[1] = 1'b1;
    step();
    ch_start[1] = 1'b0;
    repeat (5) step();
    ch_done[1] = 1'b1;
    step();
    ch_done[1] = 1'b0;
    rd_chk(1, SEL_TXN, "b2b_txn", 4'd2);
    rd_chk(1, SEL_LAST_LAT, "b2b_last", 4'd7);
    rd_chk(1, SEL_MIN_LAT, "b2b_min", mm(4'd3));
    rd_chk(1, SEL_MAX_LAT, "b2b_max", mm(4'd7));
    rd_chk(1, SEL_BUSY, "b2b_busy", 4'd10);

    // Done and start together while running: two latency-3 transactions
    ch_start[1] = 1'b1;
    step();
    ch_start[1] = 1'b0;
    step();
    ch_done[1] = 1'b1;
    ch_start[1] = 1'b1;
    step();
    ch_done[1] = 1'b0;
    ch_start[1] = 1'b0;
    step();
    ch_done[1] = 1'b1;
    step();
    ch_done[1] = 1'b0;
    rd_chk(1, SEL_TXN, "same_txn", 4'd4);
    rd_chk(1, SEL_LAST_LAT, "same_last", 4'd3);
    rd_chk(1, SEL_STATUS, "same_status", 4'd0);

    // Clear, then iterations and stalls with a disabled tail
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);
    rd_chk(1, SEL_TXN, "clr_txn", 4'd0);
    rd_chk(1, SEL_MAX_LAT, "clr_max", 4'd0);
    ch_start[0] = 1'b1;
    step();
    ch_start[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ch_iter_end[0] = 1'b1;
      ch_stall[0] = (i < 4);
      step();
    end
    ch_stall[0] = 1'b0;
    mon_en = 1'b0;
    repeat (5) step();
    ch_iter_end[0] = 1'b0;
    ch_done[0] = 1'b1;
    step();
    ch_done[0] = 1'b0;
    rd_chk(0, SEL_ITER, "it_iter", 4'd10);
    rd_chk(0, SEL_STALL, "it_stall", 4'd4);
    rd_chk(0, SEL_BUSY, "it_busy", 4'd11);
    rd_chk(0, SEL_TXN, "it_txn", 4'd0);
    rd_chk(0, SEL_LAST_LAT, "it_last", 4'd0);
    mon_en = 1'b1;

    // Read port corner cases
    rd_chk(NUM_CH, SEL_BUSY, "oob_busy", 4'd0);
    step();
    check("idle_rd_valid", 32'(rd_valid), 32'd0);
    ch_start[1] = 1'b1;
    step();
    ch_start[1] = 1'b0;
    ch_done[1] = 1'b1;
    rd_chk(1, SEL_TXN, "pre_inc_txn", 4'd0);
    ch_done[1] = 1'b0;
    rd_chk(1, SEL_TXN, "post_inc_txn", 4'd1);
    rd_chk(1, SEL_LAST_LAT, "post_inc_last", 4'd2);

    // Saturation on a long transaction, then clear
    ch_start[0] = 1'b1;
    step();
    ch_start[0] = 1'b0;
    repeat (19) step();
    check("sat_overflow", 32'(overflow), 32'b01);
    check("sat_any_busy", 32'(any_busy), 32'd1);
    rd_chk(0, SEL_BUSY, "sat_busy", 4'd15);
    rd_chk(0, SEL_STATUS, "sat_status", 4'd5);
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    check("satclr_overflow", 32'(overflow), 32'd0);
    check("satclr_any_busy", 32'(any_busy), 32'd0);
    rd_chk(0, SEL_BUSY, "satclr_busy", 4'd0);
    rd_chk(0, SEL_STATUS, "satclr_status", 4'd0);
    rd_chk(0, SEL_MIN_LAT, "satclr_min", mm(4'hF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
